// File: rtl/pic_int_sequencer_if.sv
// pic_int_sequencer_if: bundle between the PIC control/IRR logic and the interrupt sequencer.
//   i_irr       request register contents        o_int      interrupt request to the CPU
//   i_imr       mask register (1 = masked)       o_irr_clr  one-cycle IRR clear pulse
//   i_inta      active-low acknowledge (async)   o_isr      in-service register
//   i_t_base    vector base (ICW2[7:3])          o_vec      vector {t_base, level}
//   i_aeoi      automatic EOI mode               o_vec_oe   vector drive enable
//   i_rot_aeoi  rotate priority on AEOI          o_busy     sequencer not idle
//   i_eoi_cmd   one-cycle EOI strobe
//   i_eoi_spec  EOI is specific
//   i_eoi_rot   rotate priority on this EOI
//   i_eoi_level level for a specific EOI
// slave: the sequencer side. master: the control logic / CPU side.
interface pic_int_sequencer_if;
    logic [7:0] i_irr;
    logic [7:0] i_imr;
    logic       i_inta;
    logic [4:0] i_t_base;
    logic       i_aeoi;
    logic       i_rot_aeoi;
    logic       i_eoi_cmd;
    logic       i_eoi_spec;
    logic       i_eoi_rot;
    logic [2:0] i_eoi_level;
    logic       o_int;
    logic [7:0] o_irr_clr;
    logic [7:0] o_isr;
    logic [7:0] o_vec;
    logic       o_vec_oe;
    logic       o_busy;

    modport slave (
        input  i_irr, i_imr, i_inta, i_t_base, i_aeoi, i_rot_aeoi,
               i_eoi_cmd, i_eoi_spec, i_eoi_rot, i_eoi_level,
        output o_int, o_irr_clr, o_isr, o_vec, o_vec_oe, o_busy
    );

    modport master (
        output i_irr, i_imr, i_inta, i_t_base, i_aeoi, i_rot_aeoi,
               i_eoi_cmd, i_eoi_spec, i_eoi_rot, i_eoi_level,
        input  o_int, o_irr_clr, o_isr, o_vec, o_vec_oe, o_busy
    );
endinterface

// File: rtl/pic_int_sequencer.sv
// pic_int_sequencer: 8259-style interrupt sequencer.
// Resolves priority of unmasked requests against the in-service register under a rotating
// lowest-priority pointer, raises o_int, runs the two-pulse INTA handshake (ISR set and IRR
// clear on the first pulse, vector drive on the second), and services AEOI and
// specific/non-specific EOI with optional priority rotation.
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  asynchronous active-high reset
//   bus    pic_int_sequencer_if.slave, see the interface for the signal list
module pic_int_sequencer #(
    parameter int unsigned NUM_IR       = 8,
    parameter int unsigned RESET_LOWEST = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    pic_int_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StWait1, StAck1, StWait2, StAck2} state_e;

    state_e              r_state, w_state_nxt;
    logic                r_inta_s1, r_inta_s2, r_inta_prev;
    logic                r_int, w_int_nxt;
    logic [NUM_IR-1:0]   r_irr_clr, w_irr_clr_nxt;
    logic [NUM_IR-1:0]   r_isr, w_isr_nxt;
    logic [7:0]          r_vec, w_vec_nxt;
    logic                r_vec_oe, w_vec_oe_nxt;
    logic [2:0]          r_lvl, w_lvl_nxt;
    logic                r_spur, w_spur_nxt;
    logic [2:0]          r_lp, w_lp_nxt;

    logic                w_fall, w_rise;
    logic [NUM_IR-1:0]   w_pend;
    logic [2:0]          w_idx;
    logic [2:0]          w_hp_pend, w_hp_isr;
    logic [3:0]          w_rank_pend, w_rank_isr;
    logic                w_req_ok;
    logic [NUM_IR-1:0]   w_isr_set, w_isr_clr;
    logic [2:0]          w_eoi_tgt;

    // INTA synchroniser plus one extra stage for edge detection; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inta_s1   <= 1'b1;
            r_inta_s2   <= 1'b1;
            r_inta_prev <= 1'b1;
        end else begin
            r_inta_s1   <= bus.i_inta;
            r_inta_s2   <= r_inta_s1;
            r_inta_prev <= r_inta_s2;
        end
    end

    assign w_fall = r_inta_prev & ~r_inta_s2;
    assign w_rise = ~r_inta_prev & r_inta_s2;

    // Walk the order lp+1 .. lp+8 backwards so the highest-priority hit is written last.
    // Rank 0 is the highest priority; rank 8 means no bit set.
    always_comb begin
        w_pend      = bus.i_irr & ~bus.i_imr;
        w_idx       = '0;
        w_hp_pend   = '0;
        w_hp_isr    = '0;
        w_rank_pend = 4'd8;
        w_rank_isr  = 4'd8;
        for (int k = int'(NUM_IR); k >= 1; k--) begin
            w_idx = r_lp + 3'(k);
            if (w_pend[w_idx]) begin
                w_hp_pend   = w_idx;
                w_rank_pend = 4'(k - 1);
            end
            if (r_isr[w_idx]) begin
                w_hp_isr   = w_idx;
                w_rank_isr = 4'(k - 1);
            end
        end
    end

    // Fully nested: a request only wins if strictly above everything in service.
    assign w_req_ok = (w_pend != '0) && ((r_isr == '0) || (w_rank_pend < w_rank_isr));

    always_comb begin
        w_state_nxt   = r_state;
        w_int_nxt     = r_int;
        w_irr_clr_nxt = '0;
        w_vec_nxt     = r_vec;
        w_vec_oe_nxt  = r_vec_oe;
        w_lvl_nxt     = r_lvl;
        w_spur_nxt    = r_spur;
        w_lp_nxt      = r_lp;
        w_isr_set     = '0;
        w_isr_clr     = '0;
        w_eoi_tgt     = '0;

        unique case (r_state)
            StIdle: begin
                if (w_req_ok) begin
                    w_int_nxt   = 1'b1;
                    w_state_nxt = StWait1;
                end
            end
            StWait1: begin
                if (w_fall) begin
                    w_int_nxt   = 1'b0;
                    w_state_nxt = StAck1;
                    if (w_req_ok) begin
                        w_lvl_nxt                = w_hp_pend;
                        w_spur_nxt               = 1'b0;
                        w_isr_set[w_hp_pend]     = 1'b1;
                        w_irr_clr_nxt[w_hp_pend] = 1'b1;
                    end else begin
                        // Request vanished before the acknowledge: spurious IR7 vector.
                        w_lvl_nxt  = 3'd7;
                        w_spur_nxt = 1'b1;
                    end
                end
            end
            StAck1: begin
                if (w_rise) begin
                    w_state_nxt = StWait2;
                end
            end
            StWait2: begin
                if (w_fall) begin
                    w_vec_nxt    = {bus.i_t_base, r_lvl};
                    w_vec_oe_nxt = 1'b1;
                    w_state_nxt  = StAck2;
                end
            end
            StAck2: begin
                if (w_rise) begin
                    w_vec_oe_nxt = 1'b0;
                    w_state_nxt  = StIdle;
                    if (bus.i_aeoi && !r_spur) begin
                        w_isr_clr[r_lvl] = 1'b1;
                        if (bus.i_rot_aeoi) begin
                            w_lp_nxt = r_lvl;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // EOI target comes from the pre-update ISR; set and clear both apply this cycle.
        w_eoi_tgt = bus.i_eoi_spec ? bus.i_eoi_level : w_hp_isr;
        if (bus.i_eoi_cmd && (bus.i_eoi_spec || (r_isr != '0))) begin
            w_isr_clr[w_eoi_tgt] = 1'b1;
            if (bus.i_eoi_rot) begin
                w_lp_nxt = w_eoi_tgt;
            end
        end

        w_isr_nxt = (r_isr & ~w_isr_clr) | w_isr_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_int     <= 1'b0;
            r_irr_clr <= '0;
            r_isr     <= '0;
            r_vec     <= '0;
            r_vec_oe  <= 1'b0;
            r_lvl     <= '0;
            r_spur    <= 1'b0;
            r_lp      <= 3'(RESET_LOWEST);
        end else begin
            r_int     <= w_int_nxt;
            r_irr_clr <= w_irr_clr_nxt;
            r_isr     <= w_isr_nxt;
            r_vec     <= w_vec_nxt;
            r_vec_oe  <= w_vec_oe_nxt;
            r_lvl     <= w_lvl_nxt;
            r_spur    <= w_spur_nxt;
            r_lp      <= w_lp_nxt;
        end
    end

    assign bus.o_int     = r_int;
    assign bus.o_irr_clr = r_irr_clr;
    assign bus.o_isr     = r_isr;
    assign bus.o_vec     = r_vec;
    assign bus.o_vec_oe  = r_vec_oe;
    assign bus.o_busy    = (r_state != StIdle);

endmodule

// File: doc/pic_int_sequencer.md
Name: pic_int_sequencer

Overview:
- Clocked interrupt sequencer for the 8259-style PIC.
- Resolves priority among unmasked IRR bits against the in-service register (ISR) and raises int.
- Runs the two-pulse INTA acknowledge handshake, sets and clears ISR bits, and drives the 8-bit vector on the second INTA.
- Handles AEOI, specific and non-specific EOI, and automatic priority rotation.
- Sits between the control logic (which supplies ICW/OCW fields) and the IRR/ISR datapath.

Parameters:
- NUM_IR, 8, number of interrupt levels; the design is fixed at 8, so no other values are supported.
- RESET_LOWEST, 7, reset value of the lowest-priority pointer, giving IR0 the highest priority.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- irr  input  8  interrupt request register contents.
- imr  input  8  mask register (1 = masked).
- inta  input  1  active-low acknowledge from the CPU, asynchronous; double-flopped internally.
- t_base  input  5  vector base (ICW2 bits 7:3).
- aeoi  input  1  automatic EOI mode.
- rot_aeoi  input  1  rotate priority on AEOI.
- eoi_cmd  input  1  one-cycle OCW2 EOI strobe.
- eoi_spec  input  1  EOI is specific (use eoi_level).
- eoi_rot  input  1  rotate priority on this EOI.
- eoi_level  input  3  level for specific EOI.
- int  output  1  interrupt request to the CPU.
- irr_clr  output  8  one-cycle pulse clearing the acknowledged IRR bit.
- isr  output  8  in-service register.
- vec  output  8  interrupt vector, {t_base, level}.
- vec_oe  output  1  vector drive enable onto the D bus.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous):
  - int = 0, irr_clr = 0, isr = 0, vec = 0, vec_oe = 0, busy = 0.
  - Lowest-priority pointer lp = RESET_LOWEST; FSM = IDLE; the inta synchroniser flops are set to 1.
  - Reset asserted mid-handshake aborts the sequence with no ISR side effects.
- INTA edge detection:
  - inta is registered twice (s1, s2), then a third flop gives prev.
  - fall = prev & ~s2; rise = ~prev & s2. Each is a one-cycle pulse, so edges are seen 2–3 cycles after the pin.
- Priority resolution (combinational):
  - pend = irr & ~imr.
  - Priority order is lp+1, lp+2, …, lp, all mod 8. hp_pend is the first set bit of pend in that order; hp_isr is the first set bit of isr in that order.
  - req_ok = pend != 0 and (isr == 0, or hp_pend precedes hp_isr in the order). This is fully nested mode: equal or lower levels are blocked.
- FSM states:
  - IDLE: when req_ok, set int = 1 and go to WAIT1.
  - WAIT1: on fall, set int = 0.
    - If req_ok still holds: latch lvl = hp_pend, set isr[lvl], pulse irr_clr[lvl] for one cycle.
    - Else (spurious): lvl = 7, isr unchanged, no irr_clr.
    - Go to ACK1.
  - ACK1: on rise, go to WAIT2.
  - WAIT2: on fall, set vec = {t_base, lvl}, vec_oe = 1, go to ACK2.
  - ACK2: on rise, set vec_oe = 0.
    - If aeoi and not spurious: clear isr[lvl]; if rot_aeoi, set lp = lvl.
    - Go to IDLE.
- Vector drive: vec_oe is asserted from the cycle after the second fall until the cycle after the second rise.
- EOI (any state, on eoi_cmd):
  - The target is eoi_level if eoi_spec, else hp_isr.
  - Clear isr[target]; if eoi_rot, set lp = target.
  - A non-specific EOI with isr == 0 is a no-op.
- Simultaneous EOI and ISR set in the same cycle:
  - The EOI target is computed from the pre-update isr.
  - Both updates apply: isr_next = (isr & ~clr) | set.
- Other boundary rules:
  - req_ok going false in WAIT1 before fall keeps int at 1 until INTA arrives, then follows the spurious path.
  - A fall in IDLE, or a fall/rise in the wrong state, is ignored.
  - imr changes during ACK1–ACK2 do not alter lvl.
- Latency: int rises one clk after req_ok becomes true in IDLE.

Test Plan:
- Reset, irr = 0x24, imr = 0, t_base = 0x08 → int = 1; two INTA pulses → isr = 0x04, irr_clr = 0x04 pulse, vec = 0x42 with vec_oe for the second pulse only.
- isr = 0x04, irr raises bit 5 → int stays 0. irr raises bit 1 → int = 1, acknowledge gives isr = 0x06, vec low bits = 1.
- aeoi = 1, rot_aeoi = 1, irr = 0x08 → after the second rise isr = 0; next with irr = 0x09, level 0 wins (lp = 3, order 4..7,0..3).
- isr = 0x0A, non-specific EOI → isr = 0x08; specific EOI with eoi_level = 3, eoi_rot = 1 → isr = 0, lp = 3.
- irr = 0x10 raises int, irr drops to 0 before the first INTA → isr unchanged, no irr_clr, vec = {t_base, 3'd7}.
- reset asserted in ACK1 → int = 0, vec_oe = 0, isr = 0, FSM IDLE immediately (asynchronous), with no clock edge required.
